// File: rtl/alu_mc_pkg.sv
// Shared definitions for alu_mc: op codes, FSM states and the single-cycle evaluator.
// The evaluator runs on a fixed 64-bit carrier and is masked to the caller's width.
package alu_mc_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd1;
    localparam logic [OP_W-1:0] OP_PASS = 4'd2;
    localparam logic [OP_W-1:0] OP_ADDR = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_LUI  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd7;
    localparam logic [OP_W-1:0] OP_AND  = 4'd8;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd9;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Carrier width; callers must use w < MAXW so the carry bit fits.
    localparam int unsigned MAXW = 64;

    typedef struct packed {
        logic [MAXW-1:0] y;
        logic            z;
        logic            n;
        logic            c;
        logic            v;
    } alu_res_t;

    // a and b arrive zero-extended; w is the datapath width, sw the shift-amount width.
    function automatic alu_res_t alu_eval(input logic [OP_W-1:0] op,
                                          input logic [MAXW-1:0] a,
                                          input logic [MAXW-1:0] b,
                                          input int unsigned     w,
                                          input int unsigned     sw);
        alu_res_t        r;
        logic [MAXW-1:0] mask, shmask, asx, bsx, shamt, sum;
        logic            sa, sb;
        mask   = (MAXW'(1) << w) - MAXW'(1);
        shmask = (MAXW'(1) << sw) - MAXW'(1);
        sa     = a[w-1];
        sb     = b[w-1];
        asx    = sa ? (a | ~mask) : a;
        bsx    = sb ? (b | ~mask) : b;
        shamt  = b & shmask;
        sum    = '0;
        r      = '0;
        unique case (op)
            OP_ADD, OP_ADDR: begin
                sum = a + b;
                r.y = sum & mask;
                r.c = sum[w];
                r.v = (sa == sb) && (r.y[w-1] != sa);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the unsigned no-borrow flag.
                sum = a + (~b & mask) + MAXW'(1);
                r.y = sum & mask;
                r.c = sum[w];
                r.v = (sa != sb) && (r.y[w-1] != sa);
            end
            OP_PASS, OP_LUI: r.y = b;
            OP_OR:           r.y = a | b;
            OP_AND:          r.y = a & b;
            OP_XOR:          r.y = a ^ b;
            OP_SHR: r.y = (shamt >= MAXW'(w)) ? (sa ? mask : '0)
                                              : (MAXW'($signed(asx) >>> shamt) & mask);
            OP_SHL: r.y = (shamt >= MAXW'(w)) ? '0 : ((a << shamt) & mask);
            OP_SLT: r.y = MAXW'($signed(asx) < $signed(bsx));
            default: r.y = '0;
        endcase
        r.z = (r.y == '0);
        r.n = r.y[w-1];
        return r;
    endfunction

endpackage

// File: rtl/alu_mc_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
// done and prod are combinational on the final step so the caller can register them on that edge.
module mul_seq #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign prod       = w_acc_next;
    assign done       = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and response ports and registered Z/N/C/V flags.
// Single-cycle ops complete at the accept edge; MUL is handed to mul_seq for WIDTH clocks.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned SHAMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic             r_z, r_n, r_c, r_v;

    alu_res_t         w_res;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_prod;
    logic             w_unused_hi;

    assign w_res       = alu_eval(op, MAXW'(a), MAXW'(b), WIDTH, SHAMT_W);
    assign w_unused_hi = ^w_res.y[MAXW-1:WIDTH];
    assign w_is_mul    = (op == OP_MUL);

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_BUSY);

    assign y = r_y;
    assign z = r_z;
    assign n = r_n;
    assign c = r_c;
    assign v = r_v;

    mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept && w_is_mul),
        .a     (a),
        .b     (b),
        .done  (w_mul_done),
        .prod  (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A new accept in DONE takes priority over returning to IDLE.
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_y     <= w_res.y[WIDTH-1:0];
                            r_z     <= w_res.z;
                            r_n     <= w_res.n;
                            r_c     <= w_res.c;
                            r_v     <= w_res.v;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                        r_y     <= w_prod;
                        r_z     <= (w_prod == '0);
                        r_n     <= w_prod[WIDTH-1];
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=24: expectations queued at accept, compared on output handshake.
module tb_alu_mc;

    typedef struct {
        logic [23:0] y;
        logic        z, n, c, v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [23:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] y;
    logic        z, n, c, v;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    alu_mc #(
        .WIDTH   (24),
        .SHAMT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [23:0] x, input logic [23:0] w);
        exp_t        e;
        logic [24:0] s;
        logic [47:0] p;
        int          sh;
        sh  = int'(w[7:0]);
        e.c = 1'b0;
        e.v = 1'b0;
        case (o)
            4'd0, 4'd3: begin
                s   = {1'b0, x} + {1'b0, w};
                e.y = s[23:0];
                e.c = s[24];
                e.v = (x[23] == w[23]) && (e.y[23] != x[23]);
            end
            4'd1: begin
                p   = {24'd0, x} * {24'd0, w};
                e.y = p[23:0];
            end
            4'd2, 4'd5: e.y = w;
            4'd4:  e.y = x | w;
            4'd6:  e.y = (sh >= 24) ? {24{x[23]}} : 24'($signed(x) >>> sh);
            4'd7: begin
                e.y = x - w;
                e.c = (x >= w);
                e.v = (x[23] != w[23]) && (e.y[23] != x[23]);
            end
            4'd8:  e.y = x & w;
            4'd9:  e.y = x ^ w;
            4'd10: e.y = (sh >= 24) ? 24'd0 : (x << sh);
            4'd11: e.y = {23'd0, ($signed(x) < $signed(w))};
            default: e.y = 24'd0;
        endcase
        e.z = (e.y == 24'd0);
        e.n = e.y[23];
        return e;
    endfunction

    // Output monitor: a result retires when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("y", 32'(y), 32'(e.y));
                check_eq("flags_znc v", {28'd0, z, n, c, v}, {28'd0, e.z, e.n, e.c, e.v});
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [23:0] x, input logic [23:0] w);
        int   k = 0;
        logic got = 1'b0;
        op       = o;
        a        = x;
        b        = w;
        in_valid = 1'b1;
        while (!got && k < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (got) sb_q.push_back(model(o, x, w));
        else     check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (sb_q.size() != 0 && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [23:0] x;
        logic [23:0] w;
    } stim_t;

    stim_t table_s[] = '{
        '{4'd6,  24'h800000, 24'h000004},
        '{4'd6,  24'h800000, 24'h00001E},
        '{4'd6,  24'h7F0000, 24'h000104},
        '{4'd10, 24'h000001, 24'h000018},
        '{4'd10, 24'h000001, 24'h000017},
        '{4'd15, 24'h123456, 24'h654321},
        '{4'd12, 24'hFFFFFF, 24'hFFFFFF},
        '{4'd3,  24'hFFFFFF, 24'h000001},
        '{4'd2,  24'h123456, 24'hABCDEF},
        '{4'd5,  24'h000000, 24'hABC000},
        '{4'd4,  24'hF0F000, 24'h0F0F0F},
        '{4'd8,  24'hF0F0F0, 24'h3C3C3C},
        '{4'd9,  24'hAAAAAA, 24'hAAAAAA},
        '{4'd11, 24'hFFFFFF, 24'h000001},
        '{4'd11, 24'h000001, 24'hFFFFFF},
        '{4'd7,  24'h000003, 24'h000005},
        '{4'd7,  24'h800000, 24'h000001}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        a         = 24'd0;
        b         = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_flags", {28'd0, z, n, c, v}, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ADD overflow, latency 1
        send(4'd0, 24'h7FFFFF, 24'h000001);
        @(negedge clk);
        check_eq("add_latency_valid", 32'(out_valid), 32'd1);
        drain(10);

        // MUL -3*5 with ignored requests while busy
        send(4'd1, 24'hFFFFFD, 24'h000005);
        cnt = 0;
        k   = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            if (cnt == 0) begin
                check_eq("mul_in_ready", 32'(in_ready), 32'd0);
                check_eq("mul_out_valid", 32'(out_valid), 32'd0);
            end
            if (cnt == 2) begin
                op = 4'd0; a = 24'h000111; b = 24'h000222; in_valid = 1'b1;
            end
            if (cnt == 6) in_valid = 1'b0;
            cnt++;
            @(negedge clk);
            k++;
        end
        check_eq("mul_busy_cycles", 32'(cnt), 32'd24);
        drain(10);

        foreach (table_s[i]) send(table_s[i].o, table_s[i].x, table_s[i].w);
        drain(10);

        // SUB 5-5 held with out_ready low, then back-to-back ADD on release
        out_ready = 1'b0;
        send(4'd7, 24'h000005, 24'h000005);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_y", 32'(y), 32'd0);
            check_eq("hold_flags", {28'd0, z, n, c, v}, 32'b1010);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd0, 24'h000002, 24'h000003);
        drain(10);

        // Reset during the 10th busy cycle of a MUL
        send(4'd1, 24'h123456, 24'h000789);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_y", 32'(y), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(4'd0, 24'h000001, 24'h000001);
        drain(10);

        // Back-to-back: MUL accepted while DONE with out_ready high
        send(4'd9, 24'h00FF00, 24'h0F0F0F);
        send(4'd1, 24'h000007, 24'h000006);
        @(negedge clk);
        check_eq("b2b_out_valid", 32'(out_valid), 32'd0);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        drain(60);

        for (int i = 0; i < 4; i++) begin
            send(4'd1, 24'($urandom), 24'($urandom));
            send(4'($urandom_range(0, 15)), 24'($urandom), 24'($urandom_range(0, 40)));
        end
        drain(60);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
